// File: rtl/fc1_dense2_argmax_pkg.sv
// Shared definitions for the fc1 dense2 argmax stage: default sizing and FSM states.
package fc1_dense2_argmax_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_CLASSES = 8;
    localparam int DEFAULT_IDX_WIDTH   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/fc1_dense2_argmax_fp32_greater.sv
// Combinational fp32 "a strictly greater than b" using sign/magnitude ordering.
// Both zeros compare equal regardless of sign; NaNs fall out of the bit-pattern order.
module fp32_greater
    import fc1_dense2_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt
);

    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_WIDTH-2:0] mag_a;
    logic [DATA_WIDTH-2:0] mag_b;
    logic                  both_zero;

    assign sign_a    = a[DATA_WIDTH-1];
    assign sign_b    = b[DATA_WIDTH-1];
    assign mag_a     = a[DATA_WIDTH-2:0];
    assign mag_b     = b[DATA_WIDTH-2:0];
    assign both_zero = (mag_a == '0) && (mag_b == '0);

    // Positive beats negative; among negatives the smaller magnitude is larger.
    always_comb begin
        gt = 1'b0;
        if (both_zero) begin
            gt = 1'b0;
        end else if (sign_a != sign_b) begin
            gt = ~sign_a;
        end else if (!sign_a) begin
            gt = (mag_a > mag_b);
        end else begin
            gt = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fc1_dense2_argmax.sv
// Sequential argmax over the dense2 logit vector: one class compared per cycle,
// lowest index wins ties, result presented with a single-cycle valid pulse.
module fc1_dense2_argmax
    import fc1_dense2_argmax_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int IDX_WIDTH   = DEFAULT_IDX_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] data_in,
    output logic                              ready_out,
    output logic                              valid_out,
    output logic [IDX_WIDTH-1:0]              class_out,
    output logic [DATA_WIDTH-1:0]             max_out
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    argmax_state_t                      state;
    logic [NUM_CLASSES*DATA_WIDTH-1:0]  data_reg;
    logic [DATA_WIDTH-1:0]              best_val;
    logic [IDX_WIDTH-1:0]               best_idx;
    logic [IDX_WIDTH-1:0]               idx;
    logic [DATA_WIDTH-1:0]              logits [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]              cand;
    logic                               cand_gt;

    // Split the latched vector into per-class words for indexed selection.
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_split
        assign logits[k] = data_reg[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign cand = logits[idx];

    fp32_greater #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_greater (
        .a (cand),
        .b (best_val),
        .gt(cand_gt)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
            class_out <= '0;
            max_out   <= '0;
            data_reg  <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            idx       <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        data_reg  <= data_in;
                        best_val  <= data_in[DATA_WIDTH-1:0];
                        best_idx  <= '0;
                        idx       <= IDX_WIDTH'(1);
                        ready_out <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cand_gt) begin
                        best_val <= cand;
                        best_idx <= idx;
                    end
                    idx <= idx + IDX_WIDTH'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid_out <= 1'b1;
                    class_out <= best_idx;
                    max_out   <= best_val;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
